// File: rtl/lane_chart_recorder_pkg.sv
// Shared definitions for the note-lane recorder and playback lane.
// Holds the recorder state encoding, the score width and the default lane geometry.
// Pure declarations; no logic, no flow control.
package lane_chart_recorder_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RECORD = 2'd1,
    DONE   = 2'd2
  } rec_state_t;

  localparam int SCORE_W = 5;
  localparam logic [SCORE_W-1:0] SCORE_MAX = 5'd31;

  // Default chart geometry, matched by the playback lane.
  localparam int LANE_LEN_DEF = 100;
  localparam int TICK_DIV_DEF = 10000000;
  localparam int IDX_W_DEF    = 7;

  // Score counter increment that sticks at the display maximum.
  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
    return (v == SCORE_MAX) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/lane_chart_recorder_tick_gen.sv
// Slot divider: counts 0..TICK_DIV-1 while enabled and flags the last count.
// Latency: tick is decoded from the count register in the same cycle it reaches TICK_DIV-1.
// No backpressure; clr has priority over en.
module slot_tick_gen #(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count;

  assign tick = en && (count == LAST);

  // Free-running slot counter, held while disabled, wrapping after the last count.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count <= '0;
    end else if (en) begin
      count <= tick ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/lane_chart_recorder.sv
// Records lane key taps into a LANE_LEN-bit chart, one slot per TICK_DIV clocks, slot k -> chart[k].
// Latency: a key press reaches the chart 4 clocks after the key is first sampled low.
// No backpressure; start/abort are single-cycle requests and presses outside RECORD are dropped.
module lane_chart_recorder
  import lane_chart_recorder_pkg::*;
#(
  parameter int LANE_LEN = LANE_LEN_DEF,
  parameter int TICK_DIV = TICK_DIV_DEF,
  parameter int IDX_W    = IDX_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                tap_n,
  input  logic                start,
  input  logic                abort,
  output logic [LANE_LEN-1:0] chart,
  output logic                chart_valid,
  output logic                busy,
  output logic [IDX_W-1:0]    idx,
  output logic                tick,
  output logic [SCORE_W-1:0]  tap_count
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANE_LEN - 1);

  rec_state_t       state, state_nxt;
  logic             sync1, sync2, tap_prev, press;
  logic             start_ok, abort_ok, last_slot, press_ok, recording;
  logic [IDX_W-1:0] slot;

  assign recording = (state == RECORD);
  // Abort beats start when both arrive together.
  assign start_ok  = start && !abort && !recording;
  assign abort_ok  = abort && recording;
  assign last_slot = tick && (idx == LAST_IDX);
  // A press landing on a slot boundary belongs to the slot that is starting.
  assign slot      = tick ? idx + 1'b1 : idx;
  assign press_ok  = press && recording && !abort_ok && !last_slot;

  slot_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .clr   (start_ok || abort_ok),
    .en    (recording),
    .tick  (tick)
  );

  // Two-flop synchroniser for the raw key, then a registered falling-edge pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1    <= 1'b1;
      sync2    <= 1'b1;
      tap_prev <= 1'b1;
      press    <= 1'b0;
    end else begin
      sync1    <= tap_n;
      sync2    <= sync1;
      tap_prev <= sync2;
      press    <= tap_prev && !sync2;
    end
  end

  // Recorder state register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode: start from IDLE/DONE, leave RECORD on abort or after the last slot.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE, DONE: if (start_ok) state_nxt = RECORD;
      RECORD: begin
        if (abort_ok)       state_nxt = IDLE;
        else if (last_slot) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Chart, slot index, score and registered status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      chart       <= '0;
      idx         <= '0;
      tap_count   <= '0;
      busy        <= 1'b0;
      chart_valid <= 1'b0;
    end else begin
      busy        <= (state_nxt == RECORD);
      chart_valid <= (state_nxt == DONE);
      if (start_ok || abort_ok) begin
        chart     <= '0;
        idx       <= '0;
        tap_count <= '0;
      end else if (recording) begin
        if (press_ok && !chart[slot]) begin
          chart[slot] <= 1'b1;
          tap_count   <= sat_inc(tap_count);
        end
        if (tick && !last_slot) idx <= idx + 1'b1;
      end
    end
  end

endmodule

// File: doc/lane_chart_recorder.md
Name: lane_chart_recorder

Overview:
- Writer side of the note-lane format. Records a player's key taps, one slot per note tick, into a LANE_LEN-bit lane pattern.
- The playback lane consumes the result unchanged: it shifts right and judges bit 0 first, so slot k is written to chart[k].
- Sits beside the playback lane; its chart output is loaded in place of the fixed lane memory.

Parameters:
- LANE_LEN, 100, number of note slots in a chart.
- TICK_DIV, 10000000, clk cycles per note slot.
- IDX_W, 7, slot index width; must satisfy 2**IDX_W >= LANE_LEN.

Ports:
- clk  in  1  system clock (50 MHz).
- reset  in  1  synchronous, active-high reset.
- tap_n  in  1  raw lane key, active-low (KEY[3]); asynchronous to clk.
- start  in  1  one-cycle request to begin recording.
- abort  in  1  one-cycle request to cancel recording.
- chart  out  LANE_LEN  recorded lane pattern; bit k = note in slot k.
- chart_valid  out  1  high while chart holds a completed recording.
- busy  out  1  high in RECORD.
- idx  out  IDX_W  current slot index.
- tick  out  1  one-cycle pulse at each slot boundary (for LED/metronome).
- tap_count  out  5  slots marked, saturating at 31 (score-display compatible).

Behaviour:
- Reset (synchronous, active-high): state IDLE. chart=0, chart_valid=0, busy=0, idx=0, tick=0, tap_count=0, divider=0, synchroniser flops=1 (key released).
- Tap input path:
  - tap_n passes through a 2-flop synchroniser, then a falling-edge detector.
  - press = one-cycle pulse, 3 cycles after the key goes low.
  - Holding the key produces exactly one press; release produces nothing.
- States:
  - IDLE: busy=0. start -> RECORD.
  - RECORD: busy=1.
  - DONE: busy=0, chart_valid=1, chart held stable.
- Start behaviour:
  - Accepted in IDLE or DONE.
  - On the accepting cycle: chart<=0, idx<=0, tap_count<=0, chart_valid<=0, divider<=0, next state RECORD.
  - start is ignored while in RECORD.
- Divider:
  - Counts only in RECORD, 0..TICK_DIV-1.
  - tick=1 for the single cycle where divider==TICK_DIV-1; divider then wraps to 0.
  - Slot 0 therefore lasts exactly TICK_DIV cycles from the first RECORD cycle.
- Marking, on a press in RECORD:
  - Target slot s = idx, or idx+1 if tick is high that same cycle (a boundary press belongs to the new slot).
  - If chart[s]==0: set chart[s], and tap_count<=tap_count+1 unless already 31.
  - Further presses in an already-marked slot change nothing.
- Slot advance:
  - On tick with idx<LANE_LEN-1: idx<=idx+1.
  - On tick with idx==LANE_LEN-1: state DONE, chart_valid<=1, idx holds LANE_LEN-1. A press on that cycle is discarded.
- Abort:
  - In RECORD: state IDLE; chart, idx and tap_count cleared; chart_valid=0.
  - Ignored in other states.
  - start and abort in the same cycle: abort wins; start is ignored.
- Reset mid-record: same as the reset values above. No partial chart survives.
- Presses in IDLE or DONE are ignored.
- Outputs are registered; the chart bit is visible the cycle after the press pulse.

Decomposition:
- Shared package: state encoding (IDLE=2'd0, RECORD=2'd1, DONE=2'd2), SCORE_W=5, SCORE_MAX=31, default LANE_LEN and TICK_DIV shared with the playback lane.
- One sub-module: slot_tick_gen (divider with synchronous clear and enable, producing the tick pulse). Reuse it in the playback lane later.
- Synchroniser and edge detector stay inline.

Test Plan:
All scenarios use TICK_DIV=4, LANE_LEN=8.
- Reset then idle 20 cycles -> chart=0, chart_valid=0, busy=0, idx=0, no tick pulses.
- start; hold tap_n low during slots 0, 3, 7; release between them -> DONE after 32 cycles, chart=8'b1000_1001, tap_count=3, chart_valid=1.
- Three separate presses inside slot 2 -> chart[2]=1 only, tap_count=1. A press whose pulse coincides with the tick ending slot 2 -> chart[3]=1.
- Abort asserted in slot 5 with start asserted the same cycle -> IDLE, chart=0, tap_count=0. A later start records normally.
- Reset asserted mid-slot 4 -> all outputs at reset values next cycle. Press on the final tick cycle (idx=7) -> discarded; chart[7] unchanged.
- LANE_LEN=40, press in every slot -> chart all ones, tap_count saturates at 31.
